// File: rtl/shot_selector_if.sv
// Handshake bundle between the shot selector and its environment.
// master: the side that drives buttons, turn_active and valid.
// slave:  the shot selector itself.
interface shot_selector_if;
    logic       turn_active;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_fire;
    logic       valid;
    logic [2:0] fila;
    logic [2:0] columna;
    logic       enable;
    logic       shot_ok;
    logic       shot_rej;
    logic       busy;
    logic       timeout;

    modport master (
        output turn_active, btn_up, btn_down, btn_left, btn_right, btn_fire, valid,
        input  fila, columna, enable, shot_ok, shot_rej, busy, timeout
    );

    modport slave (
        input  turn_active, btn_up, btn_down, btn_left, btn_right, btn_fire, valid,
        output fila, columna, enable, shot_ok, shot_rej, busy, timeout
    );
endinterface

// File: rtl/shot_selector.sv
// shot_selector: turns push-buttons into a cursor on the battleship board,
// issues a one-cycle fire strobe to the fired-cell register and reports
// whether the shot landed on a new cell (shot_ok) or a used one (shot_rej).
// Optional feature macro: TURN_TIMEOUT_EN (idle turn timeout pulse).
module shot_selector #(
    parameter int ROWS           = 5,
    parameter int COLS           = 5,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic           clk,
    input  logic           reset,
    shot_selector_if.slave bus
);

    localparam logic [2:0] ROW_LAST = 3'(ROWS - 1);
    localparam logic [2:0] COL_LAST = 3'(COLS - 1);

    // bit positions inside the button vectors
    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;
    localparam int B_FIRE  = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FIRE = 3'd1,
        S_WAIT = 3'd2,
        S_OK   = 3'd3,
        S_REJ  = 3'd4
    } state_t;

    logic [4:0]                  btn_raw_s;
    logic [SYNC_STAGES-1:0][4:0] sync_r;
    logic [4:0]                  prev_r;
    logic [4:0]                  edge_r;
    logic                        move_s;
    logic                        expire_s;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] fila_r;
    logic [2:0] fila_nxt_s;
    logic [2:0] columna_r;
    logic [2:0] columna_nxt_s;
    logic       enable_r;
    logic       shot_ok_r;
    logic       shot_rej_r;
    logic       busy_r;
    logic       timeout_r;

    assign btn_raw_s = {bus.btn_fire, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
    assign move_s    = |edge_r[B_RIGHT:B_UP];

    // Synchronise the raw buttons and register one event per rising edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= '0;
            prev_r <= 5'b0;
            edge_r <= 5'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], btn_raw_s};
            prev_r <= sync_r[SYNC_STAGES-1];
            edge_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
        end
    end

`ifdef TURN_TIMEOUT_EN
    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tcount_r;

    // a fire edge takes precedence: the shot starts instead of timing out
    assign expire_s = (state_r == S_IDLE) && bus.turn_active && !move_s &&
                      !edge_r[B_FIRE] && (tcount_r == CNT_LAST);

    // Count idle cycles of an active turn, restarting on entry to IDLE and on movement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcount_r <= '0;
        end else if ((state_r != S_IDLE) || move_s) begin
            tcount_r <= '0;
        end else if (bus.turn_active) begin
            if (tcount_r == CNT_LAST) begin
                tcount_r <= '0;
            end else begin
                tcount_r <= tcount_r + CNT_W'(1);
            end
        end else begin
            tcount_r <= tcount_r;
        end
    end
`else
    assign expire_s = 1'b0;
`endif

    // Next state and next cursor; the cursor only moves in IDLE during an active turn
    always_comb begin
        state_nxt_s   = state_r;
        fila_nxt_s    = fila_r;
        columna_nxt_s = columna_r;
        case (state_r)
            S_IDLE: begin
                if (bus.turn_active && edge_r[B_FIRE]) begin
                    state_nxt_s = S_FIRE;
                end else if (bus.turn_active) begin
                    if (edge_r[B_UP] && !edge_r[B_DOWN]) begin
                        fila_nxt_s = (fila_r == 3'd0) ? ROW_LAST : fila_r - 3'd1;
                    end else if (edge_r[B_DOWN] && !edge_r[B_UP]) begin
                        fila_nxt_s = (fila_r == ROW_LAST) ? 3'd0 : fila_r + 3'd1;
                    end else begin
                        fila_nxt_s = fila_r;
                    end
                    if (edge_r[B_LEFT] && !edge_r[B_RIGHT]) begin
                        columna_nxt_s = (columna_r == 3'd0) ? COL_LAST : columna_r - 3'd1;
                    end else if (edge_r[B_RIGHT] && !edge_r[B_LEFT]) begin
                        columna_nxt_s = (columna_r == COL_LAST) ? 3'd0 : columna_r + 3'd1;
                    end else begin
                        columna_nxt_s = columna_r;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_FIRE: state_nxt_s = S_WAIT;
            S_WAIT: begin
                // the register updated valid on the FIRE edge
                if (bus.valid) begin
                    state_nxt_s = S_OK;
                end else begin
                    state_nxt_s = S_REJ;
                end
            end
            S_OK:    state_nxt_s = S_IDLE;
            S_REJ:   state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State, cursor and output registers; reset aborts any shot without a pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            fila_r     <= 3'd0;
            columna_r  <= 3'd0;
            enable_r   <= 1'b0;
            shot_ok_r  <= 1'b0;
            shot_rej_r <= 1'b0;
            busy_r     <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            fila_r     <= fila_nxt_s;
            columna_r  <= columna_nxt_s;
            enable_r   <= (state_nxt_s == S_FIRE);
            shot_ok_r  <= (state_nxt_s == S_OK);
            shot_rej_r <= (state_nxt_s == S_REJ);
            busy_r     <= (state_nxt_s != S_IDLE);
            timeout_r  <= expire_s;
        end
    end

    assign bus.fila     = fila_r;
    assign bus.columna  = columna_r;
    assign bus.enable   = enable_r;
    assign bus.shot_ok  = shot_ok_r;
    assign bus.shot_rej = shot_rej_r;
    assign bus.busy     = busy_r;
    assign bus.timeout  = timeout_r;

endmodule

// File: tb/tb_shot_selector.sv
// Directed bench for shot_selector with a behavioural fired-cell register.
`timescale 1ns/1ps
module tb_shot_selector;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       turn  = 1'b1;
    logic [4:0] btns  = 5'b0;   // {fire, right, left, down, up}
    logic [24:0] fired;

    int errors = 0;
    int checks = 0;
    int en_cnt = 0, ok_cnt = 0, rej_cnt = 0, busy_cnt = 0, to_cnt = 0;

    always #5 clk = ~clk;

    shot_selector_if bus();

    assign bus.turn_active = turn;
    assign bus.btn_up      = btns[0];
    assign bus.btn_down    = btns[1];
    assign bus.btn_left    = btns[2];
    assign bus.btn_right   = btns[3];
    assign bus.btn_fire    = btns[4];

    shot_selector #(
        .ROWS(5), .COLS(5), .SYNC_STAGES(2), .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // fired-cell register model: valid = 1 when the enabled cell was new
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fired     <= '0;
            bus.valid <= 1'b0;
        end else if (bus.enable) begin
            bus.valid <= ~fired[int'(bus.fila) * 5 + int'(bus.columna)];
            fired[int'(bus.fila) * 5 + int'(bus.columna)] <= 1'b1;
        end
    end

    // pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (bus.enable)   en_cnt++;
        if (bus.shot_ok)  ok_cnt++;
        if (bus.shot_rej) rej_cnt++;
        if (bus.busy)     busy_cnt++;
        if (bus.timeout)  to_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input logic [4:0] mask);
        @(negedge clk);
        btns = mask;
        repeat (6) @(negedge clk);
        btns = 5'b0;
        repeat (4) @(negedge clk);
    endtask

    // fire at the current cursor, checking the cycle-exact handshake
    task automatic fire_shot(input string tag, input logic exp_ok, input logic [2:0] ef, input logic [2:0] ec);
        int e0, o0, r0, b0;
        e0 = en_cnt; o0 = ok_cnt; r0 = rej_cnt; b0 = busy_cnt;
        @(negedge clk);
        btns[4] = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, "_en_early"}, bus.enable, 0);
        @(negedge clk);
        check({tag, "_en"}, bus.enable, 1);
        check({tag, "_fila"}, bus.fila, ef);
        check({tag, "_col"}, bus.columna, ec);
        check({tag, "_busy1"}, bus.busy, 1);
        @(negedge clk);
        check({tag, "_en_off"}, bus.enable, 0);
        check({tag, "_busy2"}, bus.busy, 1);
        @(negedge clk);
        check({tag, "_ok"}, bus.shot_ok, exp_ok);
        check({tag, "_rej"}, bus.shot_rej, !exp_ok);
        check({tag, "_busy3"}, bus.busy, 1);
        @(negedge clk);
        check({tag, "_busy_off"}, bus.busy, 0);
        btns[4] = 1'b0;
        repeat (4) @(negedge clk);
        check({tag, "_en_cnt"}, en_cnt - e0, 1);
        check({tag, "_ok_cnt"}, ok_cnt - o0, exp_ok ? 1 : 0);
        check({tag, "_rej_cnt"}, rej_cnt - r0, exp_ok ? 0 : 1);
        check({tag, "_busy_cnt"}, busy_cnt - b0, 3);
    endtask

    initial begin
        int e0, o0, r0, first_to, second_to, t0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_fila", bus.fila, 0);
        check("rst_col", bus.columna, 0);
        check("rst_en", bus.enable, 0);
        check("rst_ok", bus.shot_ok, 0);
        check("rst_rej", bus.shot_rej, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_to", bus.timeout, 0);
        reset = 1'b0;

        // 3 downs, 2 rights -> (3,2), no fire strobe
        e0 = en_cnt;
        repeat (3) press(5'b00010);
        repeat (2) press(5'b01000);
        check("move_fila", bus.fila, 3);
        check("move_col", bus.columna, 2);
        check("move_no_en", en_cnt - e0, 0);

        // wrap-around on every direction
        repeat (3) press(5'b00001);
        check("up_to0", bus.fila, 0);
        press(5'b00001);
        check("wrap_up", bus.fila, 4);
        repeat (2) press(5'b01000);
        check("right_to4", bus.columna, 4);
        press(5'b01000);
        check("wrap_right", bus.columna, 0);
        press(5'b00010);
        check("wrap_down", bus.fila, 0);
        press(5'b00100);
        check("wrap_left", bus.columna, 4);

        // up+down cancel; up+left both apply
        press(5'b00011);
        check("cancel_fila", bus.fila, 0);
        press(5'b00101);
        check("diag_fila", bus.fila, 4);
        check("diag_col", bus.columna, 3);

        // go to (2,2)
        repeat (2) press(5'b00001);
        press(5'b00100);
        check("pos_fila", bus.fila, 2);
        check("pos_col", bus.columna, 2);

        // new cell accepted, then same cell rejected
        fire_shot("shot1", 1'b1, 3'd2, 3'd2);
        fire_shot("shot2", 1'b0, 3'd2, 3'd2);
        check("rej_fila", bus.fila, 2);
        check("rej_col", bus.columna, 2);

        // fire held 100 cycles; left edge arrives while the shot is in WAIT
        e0 = en_cnt; r0 = rej_cnt;
        @(negedge clk);
        btns[4] = 1'b1;
        repeat (2) @(negedge clk);
        btns[2] = 1'b1;
        repeat (98) @(negedge clk);
        btns = 5'b0;
        repeat (6) @(negedge clk);
        check("hold_en_cnt", en_cnt - e0, 1);
        check("hold_rej_cnt", rej_cnt - r0, 1);
        check("hold_col", bus.columna, 2);

        // inactive turn: fire and move are ignored
        turn = 1'b0;
        e0 = en_cnt;
        press(5'b10000);
        press(5'b00010);
        check("noturn_en", en_cnt - e0, 0);
        check("noturn_fila", bus.fila, 2);
        turn = 1'b1;

        // turn drops after the strobe: shot still completes on new cell (3,2)
        press(5'b00010);
        check("drop_fila", bus.fila, 3);
        o0 = ok_cnt;
        @(negedge clk);
        btns[4] = 1'b1;
        repeat (4) @(negedge clk);
        check("drop_en", bus.enable, 1);
        turn = 1'b0;
        repeat (4) @(negedge clk);
        btns = 5'b0;
        check("drop_ok_cnt", ok_cnt - o0, 1);
        turn = 1'b1;
        repeat (4) @(negedge clk);

        // reset during WAIT aborts without any pulse
        o0 = ok_cnt; r0 = rej_cnt;
        @(negedge clk);
        btns[4] = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_busy_pre", bus.busy, 1);
        reset = 1'b1;
        btns  = 5'b0;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_fila", bus.fila, 0);
        repeat (3) @(negedge clk);
        check("abort_ok_cnt", ok_cnt - o0, 0);
        check("abort_rej_cnt", rej_cnt - r0, 0);

`ifdef TURN_TIMEOUT_EN
        // idle turn: pulses after edges 20 and 40 counted from reset release
        reset = 1'b0;
        first_to = -1; second_to = -1;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (bus.timeout) begin
                if (first_to < 0) first_to = i;
                else if (second_to < 0) second_to = i;
            end
        end
        check("to_first", first_to, 20);
        check("to_second", second_to, 40);
        check("to_fila", bus.fila, 0);

        // down set after edge 7 -> edge event seen at 10, counter cleared at 11,
        // so the first pulse appears after edge 31
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        first_to = -1;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            if (bus.timeout && first_to < 0) first_to = i;
            if (i == 7)  btns[1] = 1'b1;
            if (i == 10) btns[1] = 1'b0;
        end
        check("to_delayed", first_to, 31);

        // reset at cycle 15 restarts the count: no pulse within 19 cycles
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        t0 = to_cnt;
        repeat (19) @(negedge clk);
        check("to_after_rst", to_cnt - t0, 0);
`else
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("to_never", to_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
